// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller: FSM states, command pin
// encodings, address field positions and delay counter width.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACT,
        COL,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    // Row and column fields inside the byte address
    localparam int ROW_MSB = 22;
    localparam int ROW_LSB = 12;
    localparam int COL_MSB = 11;
    localparam int COL_LSB = 2;
    localparam int ROW_W   = ROW_MSB - ROW_LSB + 1;
    localparam int COL_W   = COL_MSB - COL_LSB + 1;

    // Width of the shared delay counter; timing parameters run 1..15
    localparam int CNT_W = 4;

    // Control pins of one DRAM command, all active-low
    typedef struct packed {
        logic       csn;
        logic       rasn;
        logic       casn;
        logic [3:0] wen;
    } dram_cmd_t;

    // Deselected bus, driven only while in reset
    localparam dram_cmd_t CMD_DESEL = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam dram_cmd_t CMD_NOP   = '{csn: 1'b0, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam dram_cmd_t CMD_ACT   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
    localparam dram_cmd_t CMD_PRE   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
    localparam dram_cmd_t CMD_READ  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};
    // Byte enables replace wen when a write is issued
    localparam dram_cmd_t CMD_WRITE = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'h0};

endpackage

// File: rtl/dram_delay_cnt.sv
// Down-counter shared by the precharge, activate and write-recovery waits.
// done is high whenever the count has reached zero.
module dram_delay_cnt
    import dram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dram_ctrl.sv
// Single-request DRAM controller with an open-page policy. All DRAM pins,
// req_ready and rsp_valid are registered; the command for a state is loaded
// on the edge that enters it, so it appears on the pins during that state.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int T_RP  = 5,
    parameter int T_RCD = 5,
    parameter int T_WR  = 5
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic        DRAM_valid,
    input  logic [31:0] DRAM_Q
);

    // Each wait state lasts its parameter in cycles: command plus (T-1) NOPs
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(T_WR - 1);

    state_t            state_q, state_d;
    logic              row_open_q, row_open_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              write_q, write_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    dram_cmd_t         cmd_q, cmd_d;
    logic [10:0]       dram_a_q, dram_a_d;
    logic [31:0]       dram_d_q, dram_d_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_done;

    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic              cur_write;
    logic [3:0]        cur_wstrb;
    logic [31:0]       cur_wdata;
    logic              unused_addr_bits;

    assign req_row = req_addr[ROW_MSB:ROW_LSB];
    assign req_col = req_addr[COL_MSB:COL_LSB];
    assign unused_addr_bits = &{1'b0, req_addr[31:ROW_MSB+1], req_addr[COL_LSB-1:0]};

    // Commands issued straight out of IDLE must use the request inputs,
    // since the latched copy only becomes valid on that same edge
    assign cur_row   = (state_q == IDLE) ? req_row   : row_q;
    assign cur_col   = (state_q == IDLE) ? req_col   : col_q;
    assign cur_write = (state_q == IDLE) ? req_write : write_q;
    assign cur_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    dram_delay_cnt u_delay_cnt (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // State register and all registered outputs
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            row_open_q  <= 1'b0;
            open_row_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            write_q     <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_q       <= CMD_DESEL;
            dram_a_q    <= '0;
            dram_d_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            row_q       <= row_d;
            col_q       <= col_d;
            write_q     <= write_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_q       <= cmd_d;
            dram_a_q    <= dram_a_d;
            dram_d_q    <= dram_d_d;
        end
    end

    // Next state, request capture, row tracking and delay counter control
    always_comb begin
        state_d      = state_q;
        row_open_d   = row_open_q;
        open_row_d   = open_row_q;
        row_d        = row_q;
        col_d        = col_q;
        write_d      = write_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    row_d   = req_row;
                    col_d   = req_col;
                    write_d = req_write;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    if (row_open_q && (open_row_q == req_row)) begin
                        state_d = COL;
                    end else if (!row_open_q) begin
                        state_d      = ACT;
                        cnt_load     = 1'b1;
                        cnt_load_val = RCD_LOAD;
                        row_open_d   = 1'b1;
                        open_row_d   = req_row;
                    end else begin
                        state_d      = PRE;
                        cnt_load     = 1'b1;
                        cnt_load_val = RP_LOAD;
                        row_open_d   = 1'b0;
                    end
                end
            end
            PRE: begin
                if (cnt_done) begin
                    state_d      = ACT;
                    cnt_load     = 1'b1;
                    cnt_load_val = RCD_LOAD;
                    row_open_d   = 1'b1;
                    open_row_d   = row_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACT: begin
                if (cnt_done) begin
                    state_d = COL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            COL: begin
                if (write_q) begin
                    state_d      = WR_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = WR_LOAD;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DRAM_valid) begin
                    rsp_rdata_d = DRAM_Q;
                    state_d     = RESP;
                end
            end
            WR_WAIT: begin
                if (cnt_done) begin
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin values for the coming cycle: a command only on entry to its state
    always_comb begin
        cmd_d       = CMD_NOP;
        dram_a_d    = '0;
        dram_d_d    = '0;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        if (state_d != state_q) begin
            case (state_d)
                PRE: begin
                    cmd_d = CMD_PRE;
                end
                ACT: begin
                    cmd_d    = CMD_ACT;
                    dram_a_d = cur_row;
                end
                COL: begin
                    dram_a_d = {1'b0, cur_col};
                    if (cur_write) begin
                        cmd_d     = CMD_WRITE;
                        cmd_d.wen = ~cur_wstrb;
                        dram_d_d  = cur_wdata;
                    end else begin
                        cmd_d = CMD_READ;
                    end
                end
                default: begin
                    cmd_d = CMD_NOP;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign DRAM_CSn  = cmd_q.csn;
    assign DRAM_RASn = cmd_q.rasn;
    assign DRAM_CASn = cmd_q.casn;
    assign DRAM_WEn  = cmd_q.wen;
    assign DRAM_A    = dram_a_q;
    assign DRAM_D    = dram_d_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed testbench for dram_ctrl with hand-computed command sequences.
module tb_dram_ctrl;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic        DRAM_valid;
    logic [31:0] DRAM_Q;

    int checkCount;
    int passCount;

    dram_ctrl #(
        .T_RP  (5),
        .T_RCD (5),
        .T_WR  (5)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_valid (DRAM_valid),
        .DRAM_Q     (DRAM_Q)
    );

    // 10 ns clock
    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Packs {CSn, RASn, CASn, WEn, A} into one comparable word
    function automatic logic [31:0] cmdVec(input logic csn, input logic rasn, input logic casn,
                                           input logic [3:0] wen, input logic [10:0] a);
        return {14'b0, csn, rasn, casn, wen, a};
    endfunction

    function automatic logic [31:0] pins();
        return {14'b0, DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A};
    endfunction

    function automatic logic [31:0] nopVec();
        return cmdVec(1'b0, 1'b1, 1'b1, 4'hF, 11'h000);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic write,
                                 input logic [3:0] wstrb, input logic [31:0] wdata);
        req_valid = valid;
        req_addr  = addr;
        req_write = write;
        req_wstrb = wstrb;
        req_wdata = wdata;
    endtask

    // Advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        cpu_rst    = 1'b1;
        rsp_ready  = 1'b0;
        DRAM_valid = 1'b0;
        DRAM_Q     = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_pins", pins(), cmdVec(1'b1, 1'b1, 1'b1, 4'hF, 11'h000));
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_dram_d", DRAM_D, 32'h0);
        cpu_rst = 1'b0;
        tick();
        checkOutput("idle_nop", pins(), nopVec());
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

        // Read 0x3008 from reset: closed row, ACT row 3, then READ col 2
        $display("[TB] read miss from reset");
        applyStimulus(1'b1, 32'h0000_3008, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("rd1_act", pins(), cmdVec(1'b0, 1'b0, 1'b1, 4'hF, 11'h003));
        checkOutput("rd1_ready_low", 32'(req_ready), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            // a stray DRAM_valid while activating must be ignored
            DRAM_valid = (i == 0);
            DRAM_Q     = 32'hBAD0_0001;
            tick();
            checkOutput("rd1_act_nop", pins(), nopVec());
        end
        DRAM_valid = 1'b0;
        tick();
        checkOutput("rd1_read", pins(), cmdVec(1'b0, 1'b1, 1'b0, 4'hF, 11'h002));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rd1_wait_valid", 32'(rsp_valid), 32'd0);
        end
        DRAM_valid = 1'b1;
        DRAM_Q     = 32'hDEAD_BEEF;
        tick();
        DRAM_valid = 1'b0;
        checkOutput("rd1_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Backpressure: response held for 10 cycles, stray DRAM_valid ignored
        $display("[TB] response backpressure");
        for (int i = 0; i < 10; i++) begin
            DRAM_valid = (i == 3);
            DRAM_Q     = 32'h0BAD_0BAD;
            tick();
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        DRAM_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rd1_done_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rd1_done_ready", 32'(req_ready), 32'd1);

        // Write hit 0x3010: no ACT, WRITE col 4 with WEn = ~0011
        $display("[TB] write hit");
        applyStimulus(1'b1, 32'h0000_3010, 1'b1, 4'b0011, 32'h1234_5678);
        tick();
        checkOutput("wr_write", pins(), cmdVec(1'b0, 1'b1, 1'b0, 4'b1100, 11'h004));
        checkOutput("wr_dram_d", DRAM_D, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("wr_wait_valid", 32'(rsp_valid), 32'd0);
            checkOutput("wr_wait_nop", pins(), nopVec());
        end
        tick();
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("wr_done_valid", 32'(rsp_valid), 32'd0);

        // Read 0x5000 with row 3 open: PRE, ACT row 5, READ col 0
        $display("[TB] read with row miss");
        applyStimulus(1'b1, 32'h0000_5000, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("rd2_pre", pins(), cmdVec(1'b0, 1'b0, 1'b1, 4'h0, 11'h000));
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rd2_pre_nop", pins(), nopVec());
        end
        tick();
        checkOutput("rd2_act", pins(), cmdVec(1'b0, 1'b0, 1'b1, 4'hF, 11'h005));
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rd2_act_nop", pins(), nopVec());
        end
        tick();
        checkOutput("rd2_read", pins(), cmdVec(1'b0, 1'b1, 1'b0, 4'hF, 11'h000));
        // DRAM_valid during the READ cycle itself is outside RD_WAIT
        DRAM_valid = 1'b1;
        DRAM_Q     = 32'h1111_1111;
        tick();
        checkOutput("rd2_early_valid", 32'(rsp_valid), 32'd0);
        DRAM_Q = 32'hCAFE_F00D;
        tick();
        DRAM_valid = 1'b0;
        checkOutput("rd2_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd2_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();
        checkOutput("rd2_done_valid", 32'(rsp_valid), 32'd0);

        // Reset during RD_WAIT aborts and closes the row
        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 32'h0000_5004, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("rd3_hit_read", pins(), cmdVec(1'b0, 1'b1, 1'b0, 4'hF, 11'h001));
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        checkOutput("abort_csn", 32'(DRAM_CSn), 32'd1);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
        DRAM_valid = 1'b1;
        DRAM_Q     = 32'h0000_0077;
        tick();
        DRAM_valid = 1'b0;
        checkOutput("post_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        applyStimulus(1'b1, 32'h0000_5004, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("rd4_act", pins(), cmdVec(1'b0, 1'b0, 1'b1, 4'hF, 11'h005));
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rd4_act_nop", pins(), nopVec());
        end
        tick();
        checkOutput("rd4_read", pins(), cmdVec(1'b0, 1'b1, 1'b0, 4'hF, 11'h001));
        tick();
        DRAM_valid = 1'b1;
        DRAM_Q     = 32'h55AA_55AA;
        tick();
        DRAM_valid = 1'b0;
        checkOutput("rd4_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd4_rsp_rdata", rsp_rdata, 32'h55AA_55AA);
        tick();
        checkOutput("rd4_done_ready", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter T_RP, default 5: precharge-to-activate delay, in cpu_clk cycles.
REQ-002 SHALL have parameter T_RCD, default 5: activate-to-column-command delay, in cycles.
REQ-003 SHALL have parameter T_WR, default 5: write-command-to-response delay, in cycles.
REQ-004 SHALL have port cpu_clk  in  1  sole clock; the block uses one clock; all logic is on its rising edge.
REQ-005 SHALL have port cpu_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-010 SHALL have port req_wstrb  in  4  byte enables for a write.
REQ-011 SHALL have port req_wdata  in  32  write data.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-014 SHALL have port rsp_rdata  out  32  read data; 0 for writes.
REQ-015 SHALL have port DRAM_CSn  out  1  chip select, active-low.
REQ-016 SHALL have port DRAM_RASn  out  1  row strobe, active-low.
REQ-017 SHALL have port DRAM_CASn  out  1  column strobe, active-low.
REQ-018 SHALL have port DRAM_WEn  out  4  per-byte write enable, active-low.
REQ-019 SHALL have port DRAM_A  out  11  row or column address.
REQ-020 SHALL have port DRAM_D  out  32  write data.
REQ-021 SHALL have port DRAM_valid  in  1  read data valid.
REQ-022 SHALL have port DRAM_Q  in  32  read data.

Function
REQ-023 SHALL decode row = req_addr[22:12] and col = req_addr[11:2]; DRAM_A = {1'b0, col} for column commands.
REQ-024 SHALL use FSM states IDLE, PRE, ACT, COL, RD_WAIT, WR_WAIT, RESP.
REQ-025 SHALL assert req_ready only in IDLE, and SHALL register addr/write/wstrb/wdata on acceptance.
REQ-026 SHALL encode commands as follows; each command is driven for exactly one cycle, and NOP fills all other cycles:
- NOP: CSn=0, RASn=1, CASn=1, WEn=4'hF.
- ACT: RASn=0, CASn=1, WEn=4'hF, A=row.
- PRE: RASn=0, CASn=1, WEn=4'h0.
- READ: RASn=1, CASn=0, WEn=4'hF.
- WRITE: RASn=1, CASn=0, WEn=~wstrb, D=wdata.
REQ-027 SHALL keep the row open after access (open-page policy), tracking row_open and open_row.
REQ-028 SHALL route each accepted request by row state:
- Row hit (row_open && open_row==row): IDLE->COL next cycle.
- Closed row: IDLE->ACT.
- Row miss with row open: IDLE->PRE.
REQ-029 SHALL issue PRE, then NOP for T_RP-1 cycles, then go to ACT; row_open clears at PRE.
REQ-030 SHALL issue ACT, then NOP for T_RCD-1 cycles, then go to COL; row_open sets and open_row loads at ACT.
REQ-031 SHALL issue READ or WRITE in COL, then go to RD_WAIT (read) or WR_WAIT (write).
REQ-032 SHALL in RD_WAIT wait unbounded for DRAM_valid, capture DRAM_Q into rsp_rdata in that cycle, and go to RESP.
REQ-033 SHALL in WR_WAIT count T_WR cycles, set rsp_rdata=0, and go to RESP.
REQ-034 SHALL in RESP hold rsp_valid and rsp_rdata stable until rsp_ready, then return to IDLE; back-to-back acceptance happens no earlier than the following cycle.
REQ-035 SHALL ignore DRAM_valid outside RD_WAIT.
REQ-036 SHALL use delay counters 4 bits wide, supporting parameter values 1..15; a value of 1 means no NOP padding.
REQ-037 SHALL give read-hit latency from acceptance to rsp_valid of 2 cycles plus the DRAM_valid delay after READ.

Reset
REQ-038 SHALL on cpu_rst set: state=IDLE, row_open=0, req_ready=0, rsp_valid=0, rsp_rdata=0, DRAM_CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0, counters=0.
REQ-039 SHALL on cpu_rst asserted mid-transaction abort at the next edge, with no response issued and the row treated as closed.

Structure
REQ-040 SHALL place the state enum, the command-encoding constants and the row/column bit-slice constants in shared package dram_pkg.
REQ-041 SHALL contain exactly one sub-module, dram_delay_cnt (load/decrement/done), instantiated once and shared by PRE, ACT and WR_WAIT.

Verification
REQ-042 SHALL verify: read 0x0000_3008 from reset -> ACT A=0x003, 4 NOPs, READ A=0x002; DRAM_valid 3 cycles later with Q=0xDEADBEEF -> rsp_rdata=0xDEADBEEF.
REQ-043 SHALL verify: write 0x0000_3010 wstrb=4'b0011 after REQ-042 -> no ACT (hit), WRITE WEn=4'b1100, D=wdata, rsp_valid after 5 cycles.
REQ-044 SHALL verify: read 0x0000_5000 with row 3 open -> PRE, 4 NOPs, ACT A=0x005, 4 NOPs, READ A=0x000.
REQ-045 SHALL verify: rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-046 SHALL verify: cpu_rst pulsed in RD_WAIT -> next cycle DRAM_CSn=1, rsp_valid=0; the next request to the same row issues ACT.
